// File: rtl/fpu_bcd_pkg.sv
// fpu_bcd_pkg
// Shared types and helpers for the packed-BCD to binary converter.
//   bcd_state_e   : converter FSM states (IDLE / CONV / DONE)
//   pow10(n)      : 10**n as a 128-bit constant, for elaboration-time sizing
//   num_groups    : number of DPC-digit groups covering NDIGITS digits
//   BCD_ERR_*     : bit positions inside the 2-bit error vector
package fpu_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd_state_e;

    localparam int BCD_ERR_DIGIT = 0;
    localparam int BCD_ERR_OVF   = 1;

    function automatic logic [127:0] pow10(input int n);
        logic [127:0] r;
        r = 128'd1;
        for (int i = 0; i < n; i++) r = r * 128'd10;
        return r;
    endfunction

    function automatic int num_groups(input int ndigits, input int dpc);
        return (ndigits + dpc - 1) / dpc;
    endfunction

endpackage

// File: rtl/fpu_bcd_digit_group.sv
// fpu_bcd_digit_group
// Combinational value of one group of DPC BCD digits, MSD in the top nibble.
//   nib_i     in  4*DPC : digit nibbles, digit 0 of the group in [3:0]
//   val_o     out GV_W  : sum of nibble * 10**position
//   invalid_o out 1     : some nibble is above 9
// Invalid nibbles still contribute their raw value; the sum may wrap in that
// case, which is harmless because the caller discards errored results.
module fpu_bcd_digit_group #(
    parameter int DPC  = 1,
    parameter int GV_W = 4
) (
    input  logic [4*DPC-1:0] nib_i,
    output logic [GV_W-1:0]  val_o,
    output logic             invalid_o
);

    always_comb begin
        val_o     = '0;
        invalid_o = 1'b0;
        for (int i = DPC - 1; i >= 0; i--) begin
            if (nib_i[4*i +: 4] > 4'd9) invalid_o = 1'b1;
            val_o = val_o * GV_W'(10) + GV_W'(nib_i[4*i +: 4]);
        end
    end

endmodule

// File: rtl/fpu_bcd_to_binary_param.sv
// fpu_bcd_to_binary_param
// Multi-cycle, MSD-first packed-BCD (FBLD format) to unsigned binary converter
// with valid/ready handshakes on both sides. One operand in flight at a time.
//   clk, reset           : clock (rising edge), async active-high reset
//   in_valid / in_ready  : operand handshake, in_ready high only in IDLE
//   bcd_in               : sign in the top bit, 7 ignored bits, NDIGITS nibbles
//   out_valid / out_ready: result handshake, result held until accepted
//   binary_out           : magnitude (0 when any error bit is set)
//   sign_out             : captured sign bit
//   out_err              : bit0 invalid nibble, bit1 magnitude overflow
// Optional feature macro: FPU_BCD_SKIP_LEADING_ZEROS_EN -- start conversion at
// the highest nonzero group instead of always at the top group.
module fpu_bcd_to_binary_param
    import fpu_bcd_pkg::*;
#(
    parameter int NDIGITS = 18,
    parameter int DPC     = 1,
    parameter int OUT_W   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NDIGITS+7:0]   bcd_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       binary_out,
    output logic                   sign_out,
    output logic [1:0]             out_err
);

    localparam int G     = num_groups(NDIGITS, DPC);
    localparam int PAD_W = 4 * DPC * G;
    localparam int GV_W  = $clog2(pow10(DPC));
    localparam int GI_W  = (G > 1) ? $clog2(G) : 1;
    localparam int EXT_W = OUT_W + 4 * DPC;
    localparam logic [EXT_W-1:0] P10 = EXT_W'(pow10(DPC));

    bcd_state_e        state_q, state_d;
    logic [PAD_W-1:0]  bcd_q, bcd_d;
    logic [GI_W-1:0]   grp_q, grp_d;
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic [1:0]        err_q, err_d;
    logic              sign_q, sign_d;
    logic [OUT_W-1:0]  bin_q, bin_d;
    logic              sgn_out_q, sgn_out_d;
    logic [1:0]        oerr_q, oerr_d;

    // Digits zero-padded at the MSD end up to a whole number of groups.
    logic [PAD_W-1:0]  in_digits;
    logic [GI_W-1:0]   start_grp;
    logic [4*DPC-1:0]  grp_nib;
    logic [GV_W-1:0]   grp_val;
    logic              grp_inv;
    logic [EXT_W-1:0]  acc_ext;
    logic [1:0]        err_nxt;

    assign in_digits = PAD_W'(bcd_in[4*NDIGITS-1:0]);

`ifdef FPU_BCD_SKIP_LEADING_ZEROS_EN
    // Highest group with a nonzero nibble; an all-zero operand converts
    // group 0 only, reaching DONE one cycle after accept.
    always_comb begin
        start_grp = '0;
        for (int g = 0; g < G; g++)
            if (in_digits[g*4*DPC +: 4*DPC] != '0) start_grp = GI_W'(g);
    end
`else
    assign start_grp = GI_W'(G - 1);
`endif

    assign grp_nib = bcd_q[int'(grp_q)*4*DPC +: 4*DPC];

    fpu_bcd_digit_group #(
        .DPC  (DPC),
        .GV_W (GV_W)
    ) u_group (
        .nib_i     (grp_nib),
        .val_o     (grp_val),
        .invalid_o (grp_inv)
    );

    // Widened step so overflow shows up in the bits above OUT_W.
    assign acc_ext = EXT_W'(acc_q) * P10 + EXT_W'(grp_val);

    always_comb begin
        err_nxt = err_q;
        if (grp_inv)                         err_nxt[BCD_ERR_DIGIT] = 1'b1;
        if (acc_ext[EXT_W-1:OUT_W] != '0)    err_nxt[BCD_ERR_OVF]   = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        grp_d     = grp_q;
        acc_d     = acc_q;
        err_d     = err_q;
        sign_d    = sign_q;
        bin_d     = bin_q;
        sgn_out_d = sgn_out_q;
        oerr_d    = oerr_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bcd_d   = in_digits;
                    sign_d  = bcd_in[4*NDIGITS+7];
                    acc_d   = '0;
                    err_d   = '0;
                    grp_d   = start_grp;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d = acc_ext[OUT_W-1:0];
                err_d = err_nxt;
                if (grp_q == '0) begin
                    state_d   = DONE;
                    bin_d     = (err_nxt != 2'b00) ? '0 : acc_ext[OUT_W-1:0];
                    sgn_out_d = sign_q;
                    oerr_d    = err_nxt;
                end else begin
                    grp_d = grp_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            grp_q     <= '0;
            acc_q     <= '0;
            err_q     <= '0;
            sign_q    <= 1'b0;
            bin_q     <= '0;
            sgn_out_q <= 1'b0;
            oerr_q    <= '0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            grp_q     <= grp_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
            sign_q    <= sign_d;
            bin_q     <= bin_d;
            sgn_out_q <= sgn_out_d;
            oerr_q    <= oerr_d;
        end
    end

    // Ready is masked while reset is held so nothing looks acceptable then.
    assign in_ready   = (state_q == IDLE) && !reset;
    assign out_valid  = (state_q == DONE);
    assign binary_out = bin_q;
    assign sign_out   = sgn_out_q;
    assign out_err    = oerr_q;

endmodule

// File: tb/tb_fpu_bcd_to_binary_param.sv
module tb_fpu_bcd_to_binary_param;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance: NDIGITS=18, DPC=1, OUT_W=64
    logic        iv0 = 0, ir0, ov0, or0 = 0, s0;
    logic [79:0] b0 = '0;
    logic [63:0] bo0;
    logic [1:0]  e0;
    // DPC=3 instance
    logic        iv3 = 0, ir3, ov3, or3 = 0, s3;
    logic [79:0] b3 = '0;
    logic [63:0] bo3;
    logic [1:0]  e3;
    // NDIGITS=4, OUT_W=8 instance
    logic        iv4 = 0, ir4, ov4, or4 = 0, s4;
    logic [23:0] b4 = '0;
    logic [7:0]  bo4;
    logic [1:0]  e4;

    fpu_bcd_to_binary_param d0 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .bcd_in(b0),
        .out_valid(ov0), .out_ready(or0), .binary_out(bo0), .sign_out(s0), .out_err(e0));
    fpu_bcd_to_binary_param #(.NDIGITS(18), .DPC(3), .OUT_W(64)) d3 (
        .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(ir3), .bcd_in(b3),
        .out_valid(ov3), .out_ready(or3), .binary_out(bo3), .sign_out(s3), .out_err(e3));
    fpu_bcd_to_binary_param #(.NDIGITS(4), .DPC(1), .OUT_W(8)) d4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .bcd_in(b4),
        .out_valid(ov4), .out_ready(or4), .binary_out(bo4), .sign_out(s4), .out_err(e4));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ovs(input int s);
        case (s)
            0:       return ov0;
            3:       return ov3;
            default: return ov4;
        endcase
    endfunction

    // Offer one operand, then count edges until out_valid (bounded).
    task automatic go(input int s, input logic [79:0] v, output int lat);
        @(negedge clk);
        case (s)
            0:       begin iv0 = 1; b0 = v; end
            3:       begin iv3 = 1; b3 = v; end
            default: begin iv4 = 1; b4 = v[23:0]; end
        endcase
        @(posedge clk); #1;
        iv0 = 0; iv3 = 0; iv4 = 0;
        lat = 0;
        while (!ovs(s) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic hs(input int s, input string tag);
        @(negedge clk);
        case (s)
            0:       or0 = 1;
            3:       or3 = 1;
            default: or4 = 1;
        endcase
        @(posedge clk); #1;
        check({tag, "_ovalid_low"}, 64'(ovs(s)), 64'd0);
        or0 = 0; or3 = 0; or4 = 0;
    endtask

    initial begin
        int lat;

        // Reset state
        #2;
        check("rst_in_ready", 64'(ir0), 64'd0);
        check("rst_out_valid", 64'(ov0), 64'd0);
        check("rst_binary", bo0, 64'd0);
        check("rst_sign", 64'(s0), 64'd0);
        check("rst_err", 64'(e0), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(ir0), 64'd1);

        // Invalid digit 3 = 0xA
        go(0, 80'hA000, lat);
        check("inv_lat", 64'(lat), 64'd18);
        check("inv_err", 64'(e0), 64'd1);
        check("inv_bin", bo0, 64'd0);
        hs(0, "inv");

        // +123, defaults
        go(0, 80'h0123, lat);
        check("p123_lat", 64'(lat), 64'd18);
        check("p123_bin", bo0, 64'd123);
        check("p123_sign", 64'(s0), 64'd0);
        check("p123_err", 64'(e0), 64'd0);
        hs(0, "p123");
        check("p123_hold_idle", bo0, 64'd123);

        // DPC=3: -456 then all nines
        go(3, 80'h80_000000000000000456, lat);
        check("m456_lat", 64'(lat), 64'd6);
        check("m456_bin", bo3, 64'd456);
        check("m456_sign", 64'(s3), 64'd1);
        check("m456_err", 64'(e3), 64'd0);
        hs(3, "m456");
        go(3, 80'h00_999999999999999999, lat);
        check("nines_lat", 64'(lat), 64'd6);
        check("nines_bin", bo3, 64'd999999999999999999);
        check("nines_sign", 64'(s3), 64'd0);
        check("nines_err", 64'(e3), 64'd0);
        hs(3, "nines");

        // NDIGITS=4, OUT_W=8 boundary
        go(4, 80'h0255, lat);
        check("b255_lat", 64'(lat), 64'd4);
        check("b255_bin", 64'(bo4), 64'd255);
        check("b255_err", 64'(e4), 64'd0);
        hs(4, "b255");
        go(4, 80'h0256, lat);
        check("b256_err", 64'(e4), 64'd2);
        check("b256_bin", 64'(bo4), 64'd0);
        hs(4, "b256");

        // Backpressure: 42 held for 10 cycles, second operand offered meanwhile
        go(4, 80'h0042, lat);
        check("bp_lat", 64'(lat), 64'd4);
        @(negedge clk); iv4 = 1; b4 = 24'h000099;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_ovalid", 64'(ov4), 64'd1);
            check("bp_bin", 64'(bo4), 64'd42);
            check("bp_in_ready", 64'(ir4), 64'd0);
        end
        @(negedge clk); or4 = 1;
        @(posedge clk); #1;
        or4 = 0;
        check("bp_release_ovalid", 64'(ov4), 64'd0);
        check("bp_release_in_ready", 64'(ir4), 64'd1);
        @(posedge clk); #1;       // second operand accepted here
        iv4 = 0;
        lat = 0;
        while (!ov4 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp2_lat", 64'(lat), 64'd4);
        check("bp2_bin", 64'(bo4), 64'd99);
        hs(4, "bp2");

        // Reset mid-CONV on default instance (previous result 123 is cleared)
        @(negedge clk); iv0 = 1; b0 = 80'h5678;
        @(posedge clk); #1; iv0 = 0;
        repeat (5) @(posedge clk);
        @(negedge clk); reset = 1;
        #1;
        check("mid_rst_ovalid", 64'(ov0), 64'd0);
        check("mid_rst_bin", bo0, 64'd0);
        check("mid_rst_in_ready", 64'(ir0), 64'd0);
        @(negedge clk); reset = 0;
        go(0, 80'h0001, lat);
        check("one_lat", 64'(lat), 64'd18);
        check("one_bin", bo0, 64'd1);
        check("one_err", 64'(e0), 64'd0);
        hs(0, "one");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
